// File: rtl/cache_stats_streamer.sv
`default_nettype none
// cache_stats_streamer: atomic snapshot of six 32-bit cache counters sent as a 27-byte framed stream.
// Optional macro CACHE_STATS_AUTO_EN adds a periodic internal snapshot request every AUTO_PERIOD cycles.
module cache_stats_streamer #(
   parameter logic [7:0]  HEADER      = 8'hA5,
   parameter int unsigned AUTO_PERIOD = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        snapshot_req,
   input  logic [31:0] icache_hit_counter,
   input  logic [31:0] icache_miss_counter,
   input  logic [31:0] icache_request_counter,
   input  logic [31:0] dcache_hit_counter,
   input  logic [31:0] dcache_miss_counter,
   input  logic [31:0] dcache_request_counter,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        overrun,
   output logic [7:0]  frame_seq
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND_HDR  = 3'd1,
      SEND_SEQ  = 3'd2,
      SEND_DATA = 3'd3,
      SEND_CSUM = 3'd4
   } state_t;

   localparam logic [4:0] LAST_IDX = 5'd23;

   state_t       state_q;
   logic [191:0] snap_q;
   logic [4:0]   idx_q;
   logic [7:0]   csum_q;
   logic [7:0]   out_data_q;
   logic [7:0]   seq_q;
   logic         out_valid_q;
   logic         busy_q;
   logic         overrun_q;

   logic         req_d;
   logic         accept_d;
   logic [4:0]   next_idx_d;
   logic [7:0]   next_byte_d;

   generate
      if (AUTO_PERIOD < 32) begin : g_period_check
         $error("AUTO_PERIOD must be at least 32");
      end
   endgenerate

`ifdef CACHE_STATS_AUTO_EN
   localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);

   logic [31:0] period_q;
   logic        auto_fire_d;

   assign auto_fire_d = (period_q == AUTO_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         period_q <= '0;
      end else if (auto_fire_d) begin
         period_q <= '0;
      end else begin
         period_q <= period_q + 32'd1;
      end
   end

   assign req_d = snapshot_req | auto_fire_d;
`else
   assign req_d = snapshot_req;
`endif

   assign accept_d    = out_valid_q & out_ready;
   assign next_idx_d  = idx_q + 5'd1;
   // Snapshot is packed little-endian, icache_hit in the low word, so byte k sits at bits [8k +: 8].
   assign next_byte_d = snap_q[{next_idx_d, 3'b000} +: 8];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         idx_q       <= '0;
         csum_q      <= '0;
         out_data_q  <= '0;
         seq_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // Requests arriving mid-frame are dropped, only flagged.
         if (req_d && busy_q) begin
            overrun_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (req_d) begin
                  snap_q      <= {dcache_request_counter, dcache_miss_counter, dcache_hit_counter,
                                  icache_request_counter, icache_miss_counter, icache_hit_counter};
                  seq_q       <= seq_q + 8'd1;
                  out_data_q  <= HEADER;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  csum_q      <= '0;
                  idx_q       <= '0;
                  state_q     <= SEND_HDR;
               end
            end

            SEND_HDR: begin
               if (accept_d) begin
                  csum_q     <= out_data_q;
                  out_data_q <= seq_q;
                  state_q    <= SEND_SEQ;
               end
            end

            SEND_SEQ: begin
               if (accept_d) begin
                  csum_q     <= csum_q ^ out_data_q;
                  out_data_q <= snap_q[7:0];
                  idx_q      <= '0;
                  state_q    <= SEND_DATA;
               end
            end

            SEND_DATA: begin
               if (accept_d) begin
                  csum_q <= csum_q ^ out_data_q;
                  if (idx_q == LAST_IDX) begin
                     out_data_q <= csum_q ^ out_data_q;
                     state_q    <= SEND_CSUM;
                  end else begin
                     idx_q      <= next_idx_d;
                     out_data_q <= next_byte_d;
                  end
               end
            end

            SEND_CSUM: begin
               if (accept_d) begin
                  out_data_q  <= '0;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign frame_seq = seq_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_stats_streamer.sv
`default_nettype none
// Bench for cache_stats_streamer: directed frames, expected bytes queued at request time, popped on handshake.
module tb_cache_stats_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        snapshot_req;
   logic [31:0] icache_hit_counter;
   logic [31:0] icache_miss_counter;
   logic [31:0] icache_request_counter;
   logic [31:0] dcache_hit_counter;
   logic [31:0] dcache_miss_counter;
   logic [31:0] dcache_request_counter;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        overrun;
   logic [7:0]  frame_seq;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_seq = 8'd0;

   always #5 clk = ~clk;

   cache_stats_streamer #(
      .HEADER      (8'hA5),
      .AUTO_PERIOD (64)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .snapshot_req           (snapshot_req),
      .icache_hit_counter     (icache_hit_counter),
      .icache_miss_counter    (icache_miss_counter),
      .icache_request_counter (icache_request_counter),
      .dcache_hit_counter     (dcache_hit_counter),
      .dcache_miss_counter    (dcache_miss_counter),
      .dcache_request_counter (dcache_request_counter),
      .out_data               (out_data),
      .out_valid              (out_valid),
      .out_ready              (out_ready),
      .busy                   (busy),
      .overrun                (overrun),
      .frame_seq              (frame_seq)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference frame: header, seq, 24 little-endian payload bytes, XOR checksum.
   task automatic push_frame(input logic [7:0] seq);
      logic [31:0] w [6];
      logic [7:0]  cs;
      logic [7:0]  by;
      w[0] = icache_hit_counter;
      w[1] = icache_miss_counter;
      w[2] = icache_request_counter;
      w[3] = dcache_hit_counter;
      w[4] = dcache_miss_counter;
      w[5] = dcache_request_counter;
      cs = 8'hA5 ^ seq;
      exp_q.push_back(8'hA5);
      exp_q.push_back(seq);
      for (int k = 0; k < 6; k++) begin
         for (int b = 0; b < 4; b++) begin
            by = w[k][8*b +: 8];
            exp_q.push_back(by);
            cs = cs ^ by;
         end
      end
      exp_q.push_back(cs);
   endtask

   // Raise the request for one edge and confirm the header appears one cycle later.
   task automatic start_frame(input string tag);
      snapshot_req = 1'b1;
      exp_seq = exp_seq + 8'd1;
      push_frame(exp_seq);
      tick;
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_busy"},  {31'd0, busy},      32'd1);
      check({tag, "_hdr"},   {24'd0, out_data},  32'h0000_00A5);
      check({tag, "_seq"},   {24'd0, frame_seq}, {24'd0, exp_seq});
   endtask

   task automatic run_frame(input string tag, input bit stall, input bit churn);
      int n;
      int ph;
      n  = 0;
      ph = 0;
      while (exp_q.size() != 0 && n < 400) begin
         if (stall) begin
            out_ready = (ph == 1 || ph == 2) ? 1'b0 : 1'b1;
            ph = (ph + 1) % 4;
         end
         if (churn) begin
            icache_hit_counter     = icache_hit_counter + 32'd1;
            icache_miss_counter    = icache_miss_counter + 32'd3;
            icache_request_counter = icache_request_counter + 32'd5;
            dcache_hit_counter     = dcache_hit_counter + 32'd7;
            dcache_miss_counter    = dcache_miss_counter + 32'd11;
            dcache_request_counter = dcache_request_counter + 32'd13;
         end
         tick;
         n++;
      end
      out_ready = 1'b1;
      check({tag, "_all_bytes"},  exp_q.size(), 32'd0);
      check({tag, "_busy_done"},  {31'd0, busy},      32'd0);
      check({tag, "_valid_done"}, {31'd0, out_valid}, 32'd0);
   endtask

   // Stream monitor: stable-while-stalled and byte-by-byte scoreboard comparison.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'd0;
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (prev_stall) begin
            check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
            check("stall_data_hold",  {24'd0, out_data},  {24'd0, prev_data});
         end
         if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_byte observed=0x%0h expected=none", out_data);
            end
            if (exp_q.size() != 0) begin
               check("stream_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      rst                    = 1'b0;
      snapshot_req           = 1'b0;
      out_ready              = 1'b1;
      icache_hit_counter     = '0;
      icache_miss_counter    = '0;
      icache_request_counter = '0;
      dcache_hit_counter     = '0;
      dcache_miss_counter    = '0;
      dcache_request_counter = '0;
      repeat (3) tick;
      check("rst_valid",   {31'd0, out_valid}, 32'd0);
      check("rst_data",    {24'd0, out_data},  32'd0);
      check("rst_busy",    {31'd0, busy},      32'd0);
      check("rst_overrun", {31'd0, overrun},   32'd0);
      check("rst_seq",     {24'd0, frame_seq}, 32'd0);
      rst = 1'b1;
      tick;

`ifndef CACHE_STATS_AUTO_EN
      // All-zero counters: checksum is A5^01.
      start_frame("t1");
      snapshot_req = 1'b0;
      run_frame("t1", 1'b0, 1'b0);

      // Request issued in the idle cycle right after the previous frame.
      icache_hit_counter = 32'h1122_3344;
      start_frame("t2");
      snapshot_req = 1'b0;
      run_frame("t2", 1'b0, 1'b0);

      // Stalls plus counters churning after the snapshot edge.
      tick;
      icache_hit_counter     = 32'hDEAD_BEEF;
      icache_miss_counter    = 32'h0102_0304;
      icache_request_counter = 32'hCAFE_F00D;
      dcache_hit_counter     = 32'h8000_0001;
      dcache_miss_counter    = 32'h7F7F_0000;
      dcache_request_counter = 32'hFFFF_FFFF;
      start_frame("t3");
      snapshot_req = 1'b0;
      run_frame("t3", 1'b1, 1'b1);
      check("t3_overrun", {31'd0, overrun}, 32'd0);

      // Request held through the frame: overrun, no queued second frame.
      tick;
      start_frame("t4");
      repeat (10) tick;
      check("t4_overrun_set", {31'd0, overrun}, 32'd1);
      snapshot_req = 1'b0;
      run_frame("t4", 1'b0, 1'b0);
      tick;
      check("t4_no_requeue", {31'd0, out_valid}, 32'd0);
      check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
      start_frame("t4b");
      snapshot_req = 1'b0;
      run_frame("t4b", 1'b0, 1'b0);

      // Reset while data byte 10 is on the bus.
      tick;
      icache_hit_counter     = 32'h0000_0000;
      icache_miss_counter    = 32'h0000_0000;
      icache_request_counter = 32'h00C0_FFEE;
      start_frame("t5");
      snapshot_req = 1'b0;
      repeat (12) tick;
      check("t5_abort_point", {24'd0, out_data}, 32'h0000_00C0);
      rst = 1'b0;
      tick;
      exp_q.delete();
      exp_seq = 8'd0;
      check("t5_rst_valid",   {31'd0, out_valid}, 32'd0);
      check("t5_rst_busy",    {31'd0, busy},      32'd0);
      check("t5_rst_seq",     {24'd0, frame_seq}, 32'd0);
      check("t5_rst_overrun", {31'd0, overrun},   32'd0);
      rst = 1'b1;
      tick;
      start_frame("t5b");
      snapshot_req = 1'b0;
      run_frame("t5b", 1'b0, 1'b0);
`else
      begin
         int         cyc;
         int         frames;
         int         last_start;
         logic       prev_v;
         cyc        = 0;
         frames     = 0;
         last_start = 0;
         prev_v     = 1'b0;
         while (frames < 3 && cyc < 400) begin
            tick;
            cyc++;
            if (out_valid && !prev_v) begin
               exp_seq = exp_seq + 8'd1;
               push_frame(exp_seq);
               check("auto_seq", {24'd0, frame_seq}, {24'd0, exp_seq});
               if (frames > 0) begin
                  check("auto_spacing", cyc - last_start, 32'd64);
               end
               last_start = cyc;
               frames++;
            end
            prev_v = out_valid;
         end
         check("auto_frames", frames, 32'd3);
         run_frame("auto", 1'b0, 1'b0);
         check("auto_overrun", {31'd0, overrun}, 32'd0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/cache_stats_streamer.md
Name: cache_stats_streamer

Overview:
- Sits directly downstream of the cache profiler. Consumes its six 32-bit counters.
- On request, takes an atomic snapshot of all six counters and sends it as a framed byte stream over a valid/ready interface.
- The stream feeds the debug UART / host readout path.
- Snapshot isolation means counters that keep changing during transmission never corrupt a frame.

Parameters:
- HEADER, 8'hA5, frame start byte.
- AUTO_PERIOD, 1000000, cycles between automatic snapshots (used only with the optional feature; must be ≥ 32).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- snapshot_req  in  1  level-sampled request; each cycle it is high in IDLE starts one frame.
- icache_hit_counter  in  32  from profiler.
- icache_miss_counter  in  32  from profiler.
- icache_request_counter  in  32  from profiler.
- dcache_hit_counter  in  32  from profiler.
- dcache_miss_counter  in  32  from profiler.
- dcache_request_counter  in  32  from profiler.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts byte when out_valid && out_ready.
- busy  out  1  high from snapshot until the last byte is accepted.
- overrun  out  1  sticky; set when snapshot_req is high while busy.
- frame_seq  out  8  sequence number of the frame currently or last sent.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; out_valid=0, out_data=0, busy=0, overrun=0, frame_seq=0.
  - Snapshot regs and checksum are cleared.
  - Reset mid-frame aborts the frame: out_valid is low from the next cycle and no partial completion occurs.
- States: IDLE, SEND_HDR, SEND_SEQ, SEND_DATA, SEND_CSUM.
- IDLE with snapshot_req=1 at edge N:
  - All six inputs are latched at edge N.
  - Go to SEND_HDR. busy=1 and out_valid=1 with out_data=HEADER in cycle N+1 (one-cycle latency).
- Sequence number:
  - frame_seq increments at that same edge; the first frame after reset carries seq 1.
  - Wraps 255→1? No: it wraps 255→0 (plain 8-bit modulo).
- Byte order, 27 bytes per frame:
  - HEADER, then frame_seq.
  - 24 data bytes, little-endian per word, word order: icache_hit, icache_miss, icache_request, dcache_hit, dcache_miss, dcache_request.
  - Checksum byte = XOR of all 26 preceding bytes.
- Handshake and transitions:
  - A byte advances only on out_valid && out_ready.
  - While out_ready=0, out_data and out_valid hold stable (AXI-Stream rules). out_valid never drops mid-frame.
  - SEND_DATA uses a 5-bit byte index 0..23. Index 23 accepted → SEND_CSUM.
  - SEND_CSUM accepted → IDLE, with out_valid=0 and busy=0 the next cycle.
  - A new snapshot_req is honoured no earlier than the cycle after return to IDLE, so there is one idle cycle between frames.
- Overrun:
  - snapshot_req high while busy sets overrun, and the request is dropped (not queued).
  - overrun clears only on reset.
- Counter inputs may change every cycle. Frame contents reflect only the edge-N snapshot.
- Arithmetic: the checksum is accumulated incrementally as each byte is accepted; no wide adders.

Optional Feature:
- Macro CACHE_STATS_AUTO_EN.
- Defined:
  - A free-running 32-bit period counter generates an internal request every AUTO_PERIOD cycles, OR'd with snapshot_req.
  - The counter restarts at 0 on reset and after each auto fire.
  - An auto request while busy sets overrun like an external one.
- Undefined: no period counter exists; only snapshot_req starts frames.

Test Plan:
1. Reset with all counters 0, out_ready=1, single-cycle snapshot_req → 27 bytes: A5, 01, 24×00, checksum A4 (A5^01). busy drops after byte 27.
2. icache_hit_counter=0x11223344, others 0 → bytes 3..6 = 44 33 22 11; checksum = A5^01^44^33^22^11 = E0.
3. out_ready toggling 1,0,0,1 per cycle mid-frame, with counters incrementing every cycle after the snapshot → out_data stable while stalled; frame payload equals the snapshot values.
4. snapshot_req held high during a frame → overrun=1 stays set. Exactly one frame is sent; the next frame starts after one idle cycle, with seq incremented by 1.
5. Assert rst=0 during SEND_DATA byte 10 → out_valid=0, busy=0, frame_seq=0 next cycle. A following request sends a complete frame with seq 01.
6. With CACHE_STATS_AUTO_EN, AUTO_PERIOD=64, out_ready=1 → frames start every 64 cycles with seq 1,2,3; overrun stays 0.
